// File: rtl/serial_program_loader_pkg.sv
// Shared types for the serial program loader.
//   program_loader_state_e      : loader FSM states
//   PROGRAM_LOADER_HEADER_BYTES : bytes in the little-endian length header
//   program_loader_length_t     : 32-bit image length / byte counter type
package serial_program_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    CSUM,
    FLUSH,
    DONE,
    ERR
  } program_loader_state_e;

  localparam int unsigned PROGRAM_LOADER_HEADER_BYTES = 4;

  typedef logic [31:0] program_loader_length_t;

endpackage

// File: rtl/serial_program_loader_if.sv
// Byte-stream input and memory write port of the program loader.
//   rxData/rxValid     : received byte and its one-cycle strobe
//   memAccessAddr      : byte address of the entry being written
//   memAccessWriteData : entry data, byte k in bits [8k+7:8k]
//   memAccessWE        : write request
//   memAccessBusy      : memory cannot accept this cycle
// master = loader side, slave = UART / memory side.
interface serial_program_loader_if #(
  parameter int unsigned ENTRY_BYTES = 16,
  parameter int unsigned ADDR_WIDTH  = 32
);

  logic [7:0]               rxData;
  logic                     rxValid;
  logic [ADDR_WIDTH-1:0]    memAccessAddr;
  logic [8*ENTRY_BYTES-1:0] memAccessWriteData;
  logic                     memAccessWE;
  logic                     memAccessBusy;

  modport master (
    input  rxData, rxValid, memAccessBusy,
    output memAccessAddr, memAccessWriteData, memAccessWE
  );

  modport slave (
    output rxData, rxValid, memAccessBusy,
    input  memAccessAddr, memAccessWriteData, memAccessWE
  );

endinterface

// File: rtl/serial_program_loader_entry_packer.sv
// Packs image bytes into one memory entry and holds a one-entry staging buffer.
//   clk, rstX     : clock, asynchronous active-low reset
//   wr            : a payload byte is presented this cycle
//   lane, data    : byte lane and byte value
//   push          : this byte completes the entry (last lane or final byte)
//   accept        : staging entry is being written to memory this cycle
//   staging_data  : staged entry, unfilled lanes zero
//   staging_valid : staging buffer holds an entry
//   overflow      : entry completed while staging is full and not draining
module serial_program_loader_entry_packer #(
  parameter int unsigned ENTRY_BYTES = 16
) (
  input  logic                         clk,
  input  logic                         rstX,
  input  logic                         wr,
  input  logic [$clog2(ENTRY_BYTES)-1:0] lane,
  input  logic [7:0]                   data,
  input  logic                         push,
  input  logic                         accept,
  output logic [8*ENTRY_BYTES-1:0]     staging_data,
  output logic                         staging_valid,
  output logic                         overflow
);

  logic [8*ENTRY_BYTES-1:0] assembly;
  logic [8*ENTRY_BYTES-1:0] filled;

  // Assembly register with the incoming byte merged in, so a completing
  // byte reaches staging in the same cycle it arrives.
  always_comb begin
    filled = assembly;
    filled[8*lane +: 8] = data;
  end

  assign overflow = push && staging_valid && !accept;

  always_ff @(posedge clk or negedge rstX) begin
    if (!rstX) begin
      assembly      <= '0;
      staging_data  <= '0;
      staging_valid <= 1'b0;
    end else begin
      if (wr) begin
        if (push) assembly <= '0;
        else      assembly <= filled;
      end
      // A fill in the same cycle as an accept takes over the buffer.
      if (push && !overflow) begin
        staging_data  <= filled;
        staging_valid <= 1'b1;
      end else if (accept) begin
        staging_data  <= '0;
        staging_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_program_loader.sv
// Serial program loader: takes a 4-byte little-endian length header and the
// program image from a UART byte stream, packs bytes into memory entries and
// writes them to consecutive entries from BASE_ADDR.
//   clk, rstX : clock, asynchronous active-low reset
//   bus       : serial_program_loader_if.master (rx byte stream + memory port)
//   done      : image fully written (sticky)
//   error     : header length too large or staging overflow (sticky)
// Optional: define RSD_PROGRAM_LOADER_CHECKSUM_EN to expect a 4-byte
// little-endian sum of all payload bytes after the image; a mismatch ends in
// error once all writes have drained.
module serial_program_loader
  import serial_program_loader_pkg::*;
#(
  parameter int unsigned           ENTRY_BYTES = 16,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [31:0]           MAX_BYTES   = 32'h0010_0000
) (
  input  logic                     clk,
  input  logic                     rstX,
  serial_program_loader_if.master  bus,
  output logic                     done,
  output logic                     error
);

  localparam int unsigned LANE_W    = $clog2(ENTRY_BYTES);
  localparam int unsigned HDR_CNT_W = $clog2(PROGRAM_LOADER_HEADER_BYTES);

  program_loader_state_e    state, state_next;
  program_loader_length_t   length_q, byte_count, shifted;
  logic [HDR_CNT_W-1:0]     hdr_count;
  logic [ADDR_WIDTH-1:0]    entry_addr;

  logic [LANE_W-1:0]        lane;
  logic                     byte_wr, last_byte, entry_push, hdr_last;
  logic                     we, accept, overflow, staging_valid;
  logic [8*ENTRY_BYTES-1:0] staging_data;

`ifdef RSD_PROGRAM_LOADER_CHECKSUM_EN
  program_loader_length_t sum_q, csum_q;
`endif

  always_comb begin
    lane       = byte_count[LANE_W-1:0];
    byte_wr    = (state == LOAD) && bus.rxValid;
    last_byte  = (byte_count + 32'd1) == length_q;
    entry_push = byte_wr && ((lane == LANE_W'(ENTRY_BYTES - 1)) || last_byte);
    shifted    = {bus.rxData, length_q[31:8]};
    hdr_last   = hdr_count == HDR_CNT_W'(PROGRAM_LOADER_HEADER_BYTES - 1);
    we         = staging_valid && (state != ERR) && (state != DONE);
    accept     = we && !bus.memAccessBusy;
  end

  serial_program_loader_entry_packer #(
    .ENTRY_BYTES(ENTRY_BYTES)
  ) u_packer (
    .clk          (clk),
    .rstX         (rstX),
    .wr           (byte_wr),
    .lane         (lane),
    .data         (bus.rxData),
    .push         (entry_push),
    .accept       (accept),
    .staging_data (staging_data),
    .staging_valid(staging_valid),
    .overflow     (overflow)
  );

  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (bus.rxValid && hdr_last) begin
          if (shifted == '0)           state_next = DONE;
          else if (shifted > MAX_BYTES) state_next = ERR;
          else                          state_next = LOAD;
        end
      end
      LOAD: begin
        if (overflow) state_next = ERR;
        else if (byte_wr && last_byte) begin
`ifdef RSD_PROGRAM_LOADER_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = FLUSH;
`endif
        end
      end
`ifdef RSD_PROGRAM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (bus.rxValid && hdr_last) state_next = FLUSH;
      end
`endif
      FLUSH: begin
        // Leaving on the accept cycle lets done rise right after the last write.
        if (!staging_valid || accept) begin
`ifdef RSD_PROGRAM_LOADER_CHECKSUM_EN
          state_next = (sum_q == csum_q) ? DONE : ERR;
`else
          state_next = DONE;
`endif
        end
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk or negedge rstX) begin
    if (!rstX) begin
      state      <= HDR;
      length_q   <= '0;
      byte_count <= '0;
      hdr_count  <= '0;
      entry_addr <= BASE_ADDR;
    end else begin
      state <= state_next;
      if (state == HDR && bus.rxValid) length_q <= shifted;
      // Header counter wraps to zero after the header and is reused for the checksum.
      if (bus.rxValid && (state == HDR || state == CSUM)) hdr_count <= hdr_count + 1'b1;
      if (byte_wr) byte_count <= byte_count + 32'd1;
      if (accept)  entry_addr <= entry_addr + ADDR_WIDTH'(ENTRY_BYTES);
    end
  end

`ifdef RSD_PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rstX) begin
    if (!rstX) begin
      sum_q  <= '0;
      csum_q <= '0;
    end else begin
      if (byte_wr) sum_q <= sum_q + {24'd0, bus.rxData};
      if (state == CSUM && bus.rxValid) csum_q <= {bus.rxData, csum_q[31:8]};
    end
  end
`endif

  assign bus.memAccessWE        = we;
  assign bus.memAccessAddr      = entry_addr;
  assign bus.memAccessWriteData = staging_data;
  assign done                   = (state == DONE);
  assign error                  = (state == ERR);

endmodule

// File: tb/tb_serial_program_loader.sv
// Self-checking bench for serial_program_loader. Expected memory writes are
// queued when an image is sent and compared when the DUT performs the write.
module tb_serial_program_loader;

  localparam int unsigned EB = 16;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rstX;
  logic done, error;

  serial_program_loader_if #(.ENTRY_BYTES(EB), .ADDR_WIDTH(AW)) bus ();

  serial_program_loader #(
    .ENTRY_BYTES(EB),
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (32'h0),
    .MAX_BYTES  (32'h0010_0000)
  ) dut (
    .clk  (clk),
    .rstX (rstX),
    .bus  (bus),
    .done (done),
    .error(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  int unsigned wr_count = 0;
  int unsigned last_acc_cyc = 0;
  logic [7:0]      img[$];
  logic [AW-1:0]   exp_addr_q[$];
  logic [8*EB-1:0] exp_data_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted write is checked against the oldest expected entry.
  always @(negedge clk) begin
    if (rstX && bus.memAccessWE && !bus.memAccessBusy) begin
      logic [AW-1:0]   ea;
      logic [8*EB-1:0] ed;
      wr_count++;
      last_acc_cyc = cyc;
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", bus.memAccessAddr, bus.memAccessWriteData);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (bus.memAccessAddr !== ea || bus.memAccessWriteData !== ed) begin
          errors++;
          $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                   bus.memAccessAddr, bus.memAccessWriteData, ea, ed);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rxData  = b;
    bus.rxValid = 1'b1;
    @(posedge clk); #1;
    bus.rxValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_image();
    logic [8*EB-1:0] d;
    int unsigned n = img.size();
    for (int unsigned e = 0; e * EB < n; e++) begin
      d = '0;
      for (int unsigned k = 0; k < EB && e * EB + k < n; k++) d[8*k +: 8] = img[e * EB + k];
      exp_addr_q.push_back(AW'(e * EB));
      exp_data_q.push_back(d);
    end
  endtask

  // Sends the image bytes; in checksum builds the matching sum follows.
  task automatic send_payload();
    logic [31:0] sum = 0;
    for (int i = 0; i < img.size(); i++) begin
      send_byte(img[i]);
      sum = sum + {24'd0, img[i]};
    end
`ifdef RSD_PROGRAM_LOADER_CHECKSUM_EN
    send_word(sum);
`endif
  endtask

  task automatic wait_finish(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done || error) return;
    end
  endtask

  task automatic do_reset();
    rstX = 1'b0;
    bus.rxValid = 1'b0;
    bus.rxData = 8'h00;
    bus.memAccessBusy = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(posedge clk);
    #1 rstX = 1'b1;
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_writes got=%0d exp=0", name, exp_addr_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (bus.memAccessWE !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.memAccessWE); end
    checks++; if (bus.memAccessAddr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.memAccessAddr); end
    checks++; if (bus.memAccessWriteData !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.memAccessWriteData); end
  endtask

  task automatic test_two_entries();
    int unsigned w0;
    do_reset();
    img.delete();
    for (int i = 0; i < 32; i++) img.push_back(8'(i));
    expect_image();
    w0 = wr_count;
    send_word(32'h20);
    send_payload();
    wait_finish(100);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL two_done got=%b exp=1", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL two_error got=%b exp=0", error); end
    checks++; if (wr_count - w0 != 2) begin errors++; $display("FAIL two_writes got=%0d exp=2", wr_count - w0); end
    checks++; if (cyc != last_acc_cyc + 1) begin errors++; $display("FAIL two_done_latency got=%0d exp=%0d", cyc, last_acc_cyc + 1); end
    check_queue_empty("two");
    // Bytes after completion are ignored.
    for (int i = 0; i < 20; i++) send_byte(8'hA5);
    repeat (3) @(posedge clk); #1;
    checks++; if (wr_count - w0 != 2) begin errors++; $display("FAIL done_ignores got=%0d exp=2", wr_count - w0); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_sticky got=%b exp=1", done); end
  endtask

  task automatic test_short_image();
    logic [7:0] b[5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_reset();
    img.delete();
    foreach (b[i]) img.push_back(b[i]);
    exp_addr_q.push_back('0);
    exp_data_q.push_back({{(8*EB-40){1'b0}}, 40'hEE_DDCC_BBAA});
    send_word(32'd5);
    send_payload();
    wait_finish(50);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL short_done got=%b exp=1", done); end
    check_queue_empty("short");
  endtask

  task automatic test_busy_stall();
    logic [8*EB-1:0] e0;
    do_reset();
    img.delete();
    for (int i = 0; i < 32; i++) img.push_back(8'(8'h80 + i));
    expect_image();
    e0 = exp_data_q[0];
    send_word(32'h20);
    // Busy covers the whole time entry 0 waits and drops exactly when entry 1
    // completes, so accept and refill happen in the same cycle.
    for (int i = 0; i < 32; i++) begin
      bus.memAccessBusy = (i >= 16 && i < 31);
      if (i == 30) begin
        checks++;
        if (bus.memAccessWE !== 1'b1 || bus.memAccessWriteData !== e0 || bus.memAccessAddr !== '0) begin
          errors++;
          $display("FAIL stall_stable got we=%b addr=%h data=%h exp we=1 addr=0 data=%h",
                   bus.memAccessWE, bus.memAccessAddr, bus.memAccessWriteData, e0);
        end
      end
      send_byte(img[i]);
    end
    bus.memAccessBusy = 1'b0;
`ifdef RSD_PROGRAM_LOADER_CHECKSUM_EN
    begin
      logic [31:0] s = 0;
      foreach (img[i]) s = s + {24'd0, img[i]};
      send_word(s);
    end
`endif
    wait_finish(60);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL stall_done got done=%b error=%b exp done=1 error=0", done, error); end
    check_queue_empty("stall");
  endtask

  task automatic test_overflow();
    int unsigned w0;
    do_reset();
    w0 = wr_count;
    bus.memAccessBusy = 1'b1;
    send_word(32'h20);
    for (int i = 0; i < 32; i++) send_byte(8'(i));
    repeat (4) @(posedge clk); #1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error got=%b exp=1", error); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ovf_done got=%b exp=0", done); end
    checks++; if (bus.memAccessWE !== 1'b0) begin errors++; $display("FAIL ovf_we got=%b exp=0", bus.memAccessWE); end
    bus.memAccessBusy = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (wr_count != w0) begin errors++; $display("FAIL ovf_writes got=%0d exp=0", wr_count - w0); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", error); end
  endtask

  task automatic test_too_long();
    int unsigned w0;
    do_reset();
    w0 = wr_count;
    send_word(32'hFFFF_FFFF);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL toolong_error got=%b exp=1", error); end
    for (int i = 0; i < 20; i++) send_byte(8'(i));
    checks++; if (wr_count != w0 || bus.memAccessWE !== 1'b0) begin errors++; $display("FAIL toolong_we got writes=%0d we=%b exp 0", wr_count - w0, bus.memAccessWE); end
  endtask

  task automatic test_zero_length();
    do_reset();
    send_word(32'h0);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL zero_len got done=%b error=%b exp done=1 error=0", done, error); end
  endtask

  task automatic test_reset_mid_load();
    int unsigned w0;
    do_reset();
    send_word(32'd16);
    for (int i = 0; i < 7; i++) send_byte(8'hF0 + 8'(i));
    #3 rstX = 1'b0;
    #1;
    checks++; if (done !== 1'b0 || error !== 1'b0 || bus.memAccessWE !== 1'b0) begin errors++; $display("FAIL midrst_outputs got done=%b error=%b we=%b exp 0", done, error, bus.memAccessWE); end
    @(posedge clk); #1 rstX = 1'b1;
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'(8'h40 + i * 3));
    expect_image();
    w0 = wr_count;
    send_word(32'd16);
    send_payload();
    wait_finish(50);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_done got=%b exp=1", done); end
    checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL midrst_writes got=%0d exp=1", wr_count - w0); end
    check_queue_empty("midrst");
  endtask

`ifdef RSD_PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int unsigned w0;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      exp_addr_q.push_back('0);
      exp_data_q.push_back({{(8*EB-16){1'b0}}, 16'h0201});
      w0 = wr_count;
      send_word(32'd2);
      send_byte(8'h01);
      send_byte(8'h02);
      send_word(pass == 0 ? 32'd3 : 32'd4);
      wait_finish(50);
      checks++;
      if (done !== (pass == 0) || error !== (pass != 0)) begin
        errors++;
        $display("FAIL csum_result pass=%0d got done=%b error=%b", pass, done, error);
      end
      checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL csum_writes got=%0d exp=1", wr_count - w0); end
      check_queue_empty("csum");
    end
  endtask
`endif

  initial begin
    rstX = 1'b0;
    bus.rxValid = 1'b0;
    bus.rxData = 8'h00;
    bus.memAccessBusy = 1'b0;
    test_reset();
    test_two_entries();
    test_short_image();
    test_busy_stall();
    test_overflow();
    test_too_long();
    test_zero_length();
    test_reset_mid_load();
`ifdef RSD_PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
